// File: rtl/pbit_gibbs_scheduler_if.sv
// Purpose: run control, config write port and shared p-bit drive/sample bundle for the Gibbs scheduler.
// Latency: none; plain signal bundle.
// Backpressure: none; the scheduler paces the p-bit with pbit_valid over a fixed settle window.
interface pbit_gibbs_scheduler_if #(
    parameter int N_SPIN = 4,
    parameter int ADDR_W = 5
) ();
    logic              start;
    logic [7:0]        num_sweeps;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [3:0]        cfg_data;
    logic [5:0]        pbit_in;
    logic              pbit_out;
    logic              pbit_valid;
    logic [N_SPIN-1:0] spins;
    logic              busy;
    logic              done;
    logic [7:0]        sweep_cnt;

    modport master (
        output start, num_sweeps, cfg_we, cfg_addr, cfg_data, pbit_out,
        input  pbit_in, pbit_valid, spins, busy, done, sweep_cnt
    );

    modport slave (
        input  start, num_sweeps, cfg_we, cfg_addr, cfg_data, pbit_out,
        output pbit_in, pbit_valid, spins, busy, done, sweep_cnt
    );
endinterface

// File: rtl/pbit_gibbs_scheduler.sv
// Purpose: time-multiplexes N_SPIN Ising spins onto one p-bit, running Gibbs sweeps of local-field updates.
// Latency: SETTLE+N_SPIN+2 cycles per spin update, N_SPIN times that per sweep, plus one DONE cycle per run.
// Backpressure: none; start and config writes are only accepted while idle, otherwise dropped.
module pbit_gibbs_scheduler #(
    parameter int N_SPIN = 4,
    parameter int SETTLE = 2,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    pbit_gibbs_scheduler_if.slave bus
);
    localparam int                IDX_W       = (N_SPIN > 1) ? $clog2(N_SPIN) : 1;
    localparam logic [ADDR_W-1:0] BETA_ADDR   = ADDR_W'(N_SPIN * N_SPIN + N_SPIN);
    localparam logic [ADDR_W-1:0] SPIN_ADDR   = ADDR_W'(N_SPIN * N_SPIN + N_SPIN + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_SPIN - 1);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_DRIVE, S_CAPTURE, S_DONE} state_t;
    state_t state;

    logic signed [3:0] j_mem    [N_SPIN][N_SPIN];
    logic signed [3:0] bias_mem [N_SPIN];
    logic [1:0]        beta;
    logic [N_SPIN-1:0] m;
    logic signed [7:0] acc;
    logic signed [7:0] acc_nxt;
    logic signed [7:0] j_term;
    logic signed [7:0] acc_clamp;
    logic [3:0]        act;
    logic [IDX_W-1:0]  i_q;
    logic [IDX_W-1:0]  j_q;
    logic [3:0]        settle_cnt;
    logic [7:0]        num_sweeps_q;
    logic [7:0]        sweep_cnt_q;
    logic [5:0]        pbit_in_q;
    logic              pbit_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_wr;

    // Config is frozen for the whole run, including the DONE cycle.
    assign cfg_wr = bus.cfg_we && !busy_q;

    // Coupling, bias and beta registers; the spin vector lives with the FSM since both write it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N_SPIN; r++) begin
                bias_mem[r] <= '0;
                for (int c = 0; c < N_SPIN; c++) begin
                    j_mem[r][c] <= '0;
                end
            end
            beta <= '0;
        end else if (cfg_wr) begin
            for (int r = 0; r < N_SPIN; r++) begin
                if (bus.cfg_addr == ADDR_W'(N_SPIN * N_SPIN + r)) bias_mem[r] <= bus.cfg_data;
                for (int c = 0; c < N_SPIN; c++) begin
                    if (bus.cfg_addr == ADDR_W'(r * N_SPIN + c)) j_mem[r][c] <= bus.cfg_data;
                end
            end
            if (bus.cfg_addr == BETA_ADDR) beta <= bus.cfg_data[1:0];
        end
    end

    // One local-field step (self coupling skipped) and the activation the resulting field maps to.
    always_comb begin
        j_term  = {{4{j_mem[i_q][j_q][3]}}, j_mem[i_q][j_q]};
        acc_nxt = acc;
        if (j_q != i_q) begin
            acc_nxt = m[j_q] ? (acc + j_term) : (acc - j_term);
        end
        if (acc_nxt > 8'sd7) begin
            acc_clamp = 8'sd7;
        end else if (acc_nxt < -8'sd8) begin
            acc_clamp = -8'sd8;
        end else begin
            acc_clamp = acc_nxt;
        end
        act = 4'(8'sd7 - acc_clamp);
    end

    // Sweep sequencer: LOAD bias, ACCUM couplings, DRIVE p-bit, CAPTURE sample, repeat per spin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pbit_in_q    <= '0;
            pbit_valid_q <= 1'b0;
            m            <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sweep_cnt_q  <= '0;
            num_sweeps_q <= '0;
            acc          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            settle_cnt   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_wr && bus.cfg_addr == SPIN_ADDR) m <= N_SPIN'(bus.cfg_data);
                    if (bus.start) begin
                        num_sweeps_q <= bus.num_sweeps;
                        sweep_cnt_q  <= '0;
                        i_q          <= '0;
                        busy_q       <= 1'b1;
                        if (bus.num_sweeps == 8'd0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    acc   <= {{4{bias_mem[i_q][3]}}, bias_mem[i_q]};
                    j_q   <= '0;
                    state <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc <= acc_nxt;
                    if (j_q == LAST_IDX) begin
                        pbit_in_q    <= {act, beta};
                        pbit_valid_q <= 1'b1;
                        settle_cnt   <= '0;
                        state        <= S_DRIVE;
                    end else begin
                        j_q <= j_q + IDX_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    m[i_q]       <= bus.pbit_out;
                    pbit_valid_q <= 1'b0;
                    if (i_q != LAST_IDX) begin
                        i_q   <= i_q + IDX_W'(1);
                        state <= S_LOAD;
                    end else begin
                        i_q         <= '0;
                        sweep_cnt_q <= sweep_cnt_q + 8'd1;
                        if (({1'b0, sweep_cnt_q} + 9'd1) < {1'b0, num_sweeps_q}) begin
                            state <= S_LOAD;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pbit_in    = pbit_in_q;
    assign bus.pbit_valid = pbit_valid_q;
    assign bus.spins      = m;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sweep_cnt  = sweep_cnt_q;
endmodule
